// File: rtl/arith_pkg.sv
// Shared arithmetic-practice definitions: sequencer state encoding and default operand width.
package arith_pkg;

    localparam int unsigned ARITH_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial A - B, LSB first, one full_subtractor reused per cycle with a registered borrow.
// Optional signed-overflow output is enabled by defining SUB_OVERFLOW_EN.
module four_bit_serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    sub_state_t       state, next_state;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [IDX_W-1:0] idx;
    logic             br;
    logic             fs_d, fs_bout;
`ifdef SUB_OVERFLOW_EN
    logic             a_msb, b_msb;
`endif

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ready && start) next_state = RUN;
            RUN:     if (idx == LAST_IDX) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ready      <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            idx        <= '0;
            br         <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            overflow   <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
`endif
        end else begin
            state <= next_state;
            ready <= (next_state == IDLE);
            done  <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (next_state == RUN) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        br    <= 1'b0;
                        idx   <= '0;
`ifdef SUB_OVERFLOW_EN
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {fs_d, res_sh[WIDTH-1:1]};
                    br     <= fs_bout;
                    idx    <= idx + IDX_W'(1);
                    // Outputs load with the final bit on the edge into DONE so they are valid while done=1.
                    if (next_state == DONE) begin
                        diff       <= {fs_d, res_sh[WIDTH-1:1]};
                        borrow_out <= fs_bout;
`ifdef SUB_OVERFLOW_EN
                        overflow   <= (a_msb != b_msb) && (fs_d != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_four_bit_serial_subtractor.sv
// Scoreboard bench for four_bit_serial_subtractor; honours SUB_OVERFLOW_EN when defined.
module tb_four_bit_serial_subtractor;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         ready, done, borrow_out;
    logic [W-1:0] diff;
`ifdef SUB_OVERFLOW_EN
    logic         overflow;
`endif

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    four_bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (A),
        .B          (B),
        .ready      (ready),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SUB_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.diff   = a - b;
        e.borrow = (a < b);
        e.ovf    = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
        return e;
    endfunction

    // Scoreboard: push on accepting cycle, pop and compare on done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (done === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no outstanding request");
                end else begin
                    e = sb_q.pop_front();
                    if (diff !== e.diff || borrow_out !== e.borrow) begin
                        errors++;
                        $display("FAIL result: diff=%b borrow=%b expected diff=%b borrow=%b",
                                 diff, borrow_out, e.diff, e.borrow);
                    end
`ifdef SUB_OVERFLOW_EN
                    checks++;
                    if (overflow !== e.ovf) begin
                        errors++;
                        $display("FAIL overflow: got %b expected %b", overflow, e.ovf);
                    end
`endif
                end
                checks++;
                if (prev_done === 1'b1 || ready !== 1'b0) begin
                    errors++;
                    $display("FAIL done_shape: prev_done=%b ready=%b expected 0 0", prev_done, ready);
                end
            end
            if (ready === 1'b1 && start === 1'b1) sb_q.push_back(model(A, B));
        end
        prev_done = done;
    end

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (done !== 1'b1 && n < 20);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ready=%b done=%b diff=%b borrow=%b expected 0 0 0000 0",
                     ready, done, diff, borrow_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", ready);
        end
    endtask

    task automatic test_latency();
        int n;
        wait_ready(n);
        issue(4'b0000, 4'b0000);
        wait_done(n);
        checks++;
        if (n + 1 != 5) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected 5", n + 1);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL post_done: done=%b ready=%b expected 0 1", done, ready);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] ta[5] = '{4'b0111, 4'b0011, 4'b0000, 4'b1111, 4'b0010};
        logic [W-1:0] tb[5] = '{4'b0011, 4'b0100, 4'b0001, 4'b1111, 4'b1001};
        int n;
        for (int i = 0; i < 5; i++) begin
            wait_ready(n);
            issue(ta[i], tb[i]);
            // Start pulse with different operands during RUN must be ignored.
            A = 4'b0101; B = 4'b0110; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_run: got %b expected 0", ready);
            end
            wait_done(n);
            checks++;
            if (n != 3) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got %0d expected 3", i, n);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int done_at[$];
        wait_ready(n);
        A = 4'b1010; B = 4'b0101; start = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            @(posedge clk); #1;
            if (c % 6 == 1) A = 4'b0000;
            if (c % 6 == 4) A = 4'b1010;
            if (done === 1'b1) begin
                done_at.push_back(c);
                checks++;
                if (diff !== 4'b0101 || borrow_out !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result: diff=%b borrow=%b expected 0101 0", diff, borrow_out);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (done_at.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d results expected 3", done_at.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (done_at[i] - done_at[i-1] != 6) begin
                    errors++;
                    $display("FAIL b2b_spacing: got %0d expected 6", done_at[i] - done_at[i-1]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int n;
        wait_ready(n);
        issue(4'b0010, 4'b0001);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (ready !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: ready=%b done=%b diff=%b borrow=%b expected 0 0 0000 0",
                     ready, done, diff, borrow_out);
        end
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready: got %b expected 1", ready);
        end
        issue(4'b1001, 4'b0011);
        wait_done(n);
        checks++;
        if (n + 1 != 5 || diff !== 4'b0110) begin
            errors++;
            $display("FAIL after_reset_op: latency=%0d diff=%b expected 5 0110", n + 1, diff);
        end
    endtask

`ifdef SUB_OVERFLOW_EN
    task automatic test_overflow();
        int n;
        wait_ready(n);
        issue(4'b1000, 4'b0001);
        wait_done(n);
        checks++;
        if (overflow !== 1'b1 || diff !== 4'b0111) begin
            errors++;
            $display("FAIL ovf_set: overflow=%b diff=%b expected 1 0111", overflow, diff);
        end
        @(posedge clk); #1;
        issue(4'b0101, 4'b0011);
        wait_done(n);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: overflow=%b expected 0", overflow);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_basic();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SUB_OVERFLOW_EN
        test_overflow();
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_bit_serial_subtractor.md
# four_bit_serial_subtractor

Bit-serial 4-bit subtractor that computes A − B one bit per clock, LSB first, and returns the difference and a borrow flag. It is the inverse of the combinational ripple adder: one full-subtractor cell is reused across cycles, and a registered borrow replaces the rippled carry chain. It sits beside the adder in the arithmetic practice set and uses a start/ready/done handshake so a sequencer or testbench can drive it.

## Interface
- WIDTH, 4, operand and result width in bits; the bit counter is sized for WIDTH.
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- A  input  WIDTH  minuend; sampled when start is accepted.
- B  input  WIDTH  subtrahend; sampled when start is accepted.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when diff and borrow_out are updated.
- diff  output  WIDTH  result A − B mod 2^WIDTH; held between operations.
- borrow_out  output  1  high when A < B (unsigned); held between operations.
- overflow  output  1  signed overflow; present only with SUB_OVERFLOW_EN.

## Operation
- Reset values: ready=0 during the reset cycle, then 1. done=0, diff=0, borrow_out=0, overflow=0. Internal state is IDLE.
- States:
  - IDLE: ready=1. If start=1, latch A into a_sh and B into b_sh, clear the borrow flip-flop and the bit index, then go to RUN. If start=0, stay in IDLE.
  - RUN: ready=0. Each cycle, compute on bit 0 of the shift registers:
    - d = a ^ b ^ br
    - br_next = (~a & b) | (~(a ^ b) & br)
    - Shift d into the MSB of res_sh, shift a_sh and b_sh right, and increment the index.
    - After WIDTH RUN cycles, go to DONE.
  - DONE: ready=0, done=1. Copy res_sh to diff and the final borrow to borrow_out, then return to IDLE.
- diff and borrow_out change only on entry to DONE; partial results are never visible.
- A and B may change freely after acceptance.
- start while ready=0 is ignored. It is not queued.
- Reset mid-operation abandons the operation and returns every output to its reset value.
- Unsigned wrap: diff = (A + ~B + 1) mod 2^WIDTH. Example: 0 − 1 gives diff=all-ones, borrow_out=1.

## Timing
- Cycle 0: IDLE with start=1. The request is accepted at this edge.
- Cycles 1..WIDTH: RUN, one bit per cycle.
- Cycle WIDTH+1: DONE. done=1, and diff/borrow_out are valid from this cycle.
- Cycle WIDTH+2: IDLE, ready=1. Another start is accepted at this edge.
- Latency is WIDTH+1 cycles from the accepting edge to done. For WIDTH=4 that is 5 cycles, with a minimum issue interval of 6 cycles.
- done is never high for two consecutive cycles.

## Configuration
- SUB_OVERFLOW_EN defined:
  - Adds the overflow port: overflow = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]), using the latched operands.
  - overflow is registered and updated with diff in DONE.
- SUB_OVERFLOW_EN undefined:
  - Port and logic are absent.
  - diff and borrow_out behaviour is unchanged.

## Structure
- Shared package arith_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default width constant ARITH_WIDTH=4.
- One sub-module: full_subtractor.
  - Inputs a, b, bin; outputs d, bout; purely combinational.
  - Instantiated once and fed from bit 0 of the shift registers.
- The top level holds the FSM, shift registers, bit index, borrow flip-flop and output registers.

## Test plan
- A=0000, B=0000, start pulse -> done exactly 5 cycles after acceptance; diff=0000, borrow_out=0.
- A=0111, B=0011 -> diff=0100, borrow_out=0. Then A=0011, B=0100 -> diff=1111, borrow_out=1.
- A=0000, B=0001 -> diff=1111, borrow_out=1. A=1111, B=1111 -> diff=0000, borrow_out=0.
- start held high continuously with A=1010, B=0101 -> results spaced 6 cycles apart, diff=0101; start pulses during RUN or DONE are ignored, and A changed mid-RUN does not alter the result.
- rst asserted in the 2nd RUN cycle -> next cycle ready=0, done=0, diff=0, borrow_out=0; ready=1 the cycle after; a new op A=1001, B=0011 then gives diff=0110.
- With SUB_OVERFLOW_EN: A=1000, B=0001 -> diff=0111, borrow_out=0, overflow=1. A=0101, B=0011 -> overflow=0.
